instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream neighbour of the instruction decode/control FSM.
- Owns the program counter and issues reads to a synchronous-read instruction memory.
- Presents one 16-bit instruction at a time to the decode FSM, holding it stable until the FSM acknowledges it.
- Accepts jump redirects from the control path.

Parameters:
ADDR_W, 16, width of PC and memory address
RESET_PC, 0, PC value loaded on reset
MEM_LAT, 1, cycles from MemRdEn sampled to MemData valid (1..4)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  synchronous reset, active-high
MemAddr  output  ADDR_W  instruction memory read address (registered)
MemRdEn  output  1  memory read strobe, one cycle per fetch (registered)
MemData  input  16  memory read data, valid MEM_LAT cycles after the MemRdEn cycle
Instr  output  16  current instruction to decode FSM
InstrValid  output  1  Instr holds a fetched, unconsumed instruction
InstrAck  input  1  decode FSM has consumed Instr
Jump  input  1  redirect request
JumpAddr  input  ADDR_W  redirect target
PC  output  ADDR_W  address of the next word to fetch
Halted  output  1  halt word captured (see Optional Feature)

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values:
  - PC=RESET_PC, MemAddr=RESET_PC, MemRdEn=0.
  - Instr=16'h0000, InstrValid=0, Halted=0.
  - State=FETCH, latency counter=0.
- States:
  - FETCH:
    - MemAddr<=PC, MemRdEn<=1 for exactly one cycle.
    - Counter<=MEM_LAT.
    - Next state WAIT.
  - WAIT:
    - MemRdEn=0; counter decrements each cycle.
    - In the cycle the counter reaches 1: Instr<=MemData, InstrValid<=1, PC<=PC+1, next state HOLD.
  - HOLD:
    - Instr and InstrValid are held stable.
    - On InstrAck=1: InstrValid<=0, next state FETCH.
    - InstrAck while InstrValid=0 is ignored.
  - HALT (feature only): InstrValid=0, MemRdEn=0; exits only on Jump or Rst.
- Latency and throughput (MEM_LAT=1):
  - MemRdEn high in cycle n; MemData sampled in cycle n+1; InstrValid high from cycle n+2.
  - Ack in cycle k gives the next InstrValid in cycle k+3.
- Jump handling:
  - Jump=1 in any state: PC<=JumpAddr, InstrValid<=0, Halted<=0, in-flight read discarded, next state FETCH.
  - Jump has priority over InstrAck and over a capture in the same cycle.
- PC arithmetic:
  - Modulo 2^ADDR_W; PC=all-ones increments to 0 with no flag.
  - JumpAddr is used unmodified.
- Rst has priority over Jump and all other inputs, including mid-WAIT; any outstanding memory response is ignored.
- MemData is sampled only in the capture cycle; its value at all other times has no effect.

Optional Feature:
- Macro: INSTR_FETCH_HALT_DETECT_EN
- Defined:
  - A captured word equal to 16'h40F0 (halt/wait encoding) still asserts InstrValid and is delivered normally.
  - On its InstrAck: Halted<=1, next state HALT; PC stays at halt address+1; no further MemRdEn.
  - Jump clears Halted and resumes fetching at JumpAddr.
- Undefined:
  - Halted is tied 0 and the HALT state is absent.
  - 16'h40F0 is fetched and acked like any other word; fetching continues.

Test Plan:
- Reset: assert Rst 2 cycles with RESET_PC=0 -> MemAddr=0, InstrValid=0, Instr=0; after release, MemRdEn=1 for 1 cycle with MemAddr=0.
- Sequential fetch: memory words 0x1234, 0x5678, 0x9ABC; Ack 1 cycle after each InstrValid -> Instr shows the three values in order, PC=3, each InstrValid rising 3 cycles after the prior Ack.
- Backpressure: hold InstrAck=0 for 10 cycles -> Instr=0x1234 stable, InstrValid=1, no MemRdEn pulses; Ack -> next fetch at address 1.
- Jump mid-WAIT: Jump=1, JumpAddr=0x0040 in the cycle after MemRdEn -> old data not presented; next MemRdEn at MemAddr=0x0040; Jump simultaneous with Ack -> jump wins.
- Wrap: Jump to 0xFFFF, fetch and Ack -> PC=0x0000 and next MemAddr=0x0000.
- Halt (feature on): word 0x40F0 at address 5, Ack -> Halted=1, no MemRdEn for 20 cycles; Jump to 0x0010 -> Halted=0, fetch resumes at 0x0010. With feature off: same stimulus -> fetch continues at address 6.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory read port, the decode
// handshake and the jump redirect of the fetch unit.
//   master (fetch unit): drives MemAddr, MemRdEn, Instr, InstrValid, PC,
//                        Halted; receives MemData, InstrAck, Jump, JumpAddr.
//   slave  (environment): the mirror image of master.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRdEn;
  logic [15:0]       MemData;
  logic [15:0]       Instr;
  logic              InstrValid;
  logic              InstrAck;
  logic              Jump;
  logic [ADDR_W-1:0] JumpAddr;
  logic [ADDR_W-1:0] PC;
  logic              Halted;

  modport master (
    output MemAddr, MemRdEn, Instr, InstrValid, PC, Halted,
    input  MemData, InstrAck, Jump, JumpAddr
  );

  modport slave (
    input  MemAddr, MemRdEn, Instr, InstrValid, PC, Halted,
    output MemData, InstrAck, Jump, JumpAddr
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: owns the program counter, reads a synchronous instruction
// memory and hands one 16-bit word at a time to the decode FSM, holding it
// until acknowledged. Jump redirects the PC and drops any in-flight read.
// Ports:
//   Clk  - clock, all state changes on the rising edge
//   Rst  - synchronous active-high reset (priority over everything)
//   bus  - instr_fetch_if.master: memory read port (MemAddr, MemRdEn,
//          MemData), decode handshake (Instr, InstrValid, InstrAck),
//          redirect (Jump, JumpAddr), PC and Halted status.
// Optional build macro: INSTR_FETCH_HALT_DETECT_EN enables the halt-word
// detection (16'h40F0) and the HALT state; otherwise Halted is tied low.
module instr_fetch #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter int                 MEM_LAT  = 1
) (
  input logic            Clk,
  input logic            Rst,
  instr_fetch_if.master  bus
);

  localparam logic [2:0]        LAT    = 3'(MEM_LAT);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef INSTR_FETCH_HALT_DETECT_EN
  localparam logic [15:0]       HALT_WORD = 16'h40F0;
`endif

  // FETCH spans the read-issue cycle: it is entered with MemRdEn low (after
  // reset or a jump) and raises it, or entered with MemRdEn already high
  // (after an ack, so the next read is not delayed) and moves to WAIT.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
`ifdef INSTR_FETCH_HALT_DETECT_EN
    , ST_HALT = 2'd3
`endif
  } state_t;

  state_t            state_r, state_nxt;
  logic [ADDR_W-1:0] pc_r, pc_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic              rd_en_r, rd_en_nxt;
  logic [2:0]        cnt_r, cnt_nxt;
  logic [15:0]       instr_r, instr_nxt;
  logic              valid_r, valid_nxt;
`ifdef INSTR_FETCH_HALT_DETECT_EN
  logic              halted_r, halted_nxt;
`endif

  // Next-state and next-register values; Jump overrides every state action.
  always_comb begin
    state_nxt = state_r;
    pc_nxt    = pc_r;
    addr_nxt  = addr_r;
    rd_en_nxt = 1'b0;
    cnt_nxt   = cnt_r;
    instr_nxt = instr_r;
    valid_nxt = valid_r;
`ifdef INSTR_FETCH_HALT_DETECT_EN
    halted_nxt = halted_r;
`endif
    if (bus.Jump) begin
      pc_nxt    = bus.JumpAddr;
      valid_nxt = 1'b0;
      cnt_nxt   = 3'd0;
      state_nxt = ST_FETCH;
`ifdef INSTR_FETCH_HALT_DETECT_EN
      halted_nxt = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (rd_en_r) begin
            cnt_nxt   = LAT;
            state_nxt = ST_WAIT;
          end else begin
            addr_nxt  = pc_r;
            rd_en_nxt = 1'b1;
          end
        end
        ST_WAIT: begin
          // Counter reads 1 in the cycle MemData carries the response.
          if (cnt_r == 3'd1) begin
            instr_nxt = bus.MemData;
            valid_nxt = 1'b1;
            pc_nxt    = pc_r + PC_ONE;
            state_nxt = ST_HOLD;
          end else begin
            cnt_nxt = cnt_r - 3'd1;
          end
        end
        ST_HOLD: begin
          if (bus.InstrAck) begin
            valid_nxt = 1'b0;
`ifdef INSTR_FETCH_HALT_DETECT_EN
            if (instr_r == HALT_WORD) begin
              halted_nxt = 1'b1;
              state_nxt  = ST_HALT;
            end else begin
              addr_nxt  = pc_r;
              rd_en_nxt = 1'b1;
              state_nxt = ST_FETCH;
            end
`else
            addr_nxt  = pc_r;
            rd_en_nxt = 1'b1;
            state_nxt = ST_FETCH;
`endif
          end else begin
            state_nxt = ST_HOLD;
          end
        end
`ifdef INSTR_FETCH_HALT_DETECT_EN
        ST_HALT: begin
          state_nxt = ST_HALT;
        end
`endif
        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      rd_en_r <= 1'b0;
      cnt_r   <= 3'd0;
      instr_r <= 16'h0000;
      valid_r <= 1'b0;
`ifdef INSTR_FETCH_HALT_DETECT_EN
      halted_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      addr_r  <= addr_nxt;
      rd_en_r <= rd_en_nxt;
      cnt_r   <= cnt_nxt;
      instr_r <= instr_nxt;
      valid_r <= valid_nxt;
`ifdef INSTR_FETCH_HALT_DETECT_EN
      halted_r <= halted_nxt;
`endif
    end
  end

  assign bus.MemAddr    = addr_r;
  assign bus.MemRdEn    = rd_en_r;
  assign bus.Instr      = instr_r;
  assign bus.InstrValid = valid_r;
  assign bus.PC         = pc_r;
`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign bus.Halted     = halted_r;
`else
  assign bus.Halted     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch (ADDR_W=16, RESET_PC=0, MEM_LAT=1). A memory model
// answers reads one cycle after MemRdEn and drives random junk otherwise.
// A reference model tracks only the address of the word the decode side is
// owed next; directed steps follow the test plan, then a random phase.
module tb_instr_fetch;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  instr_fetch_if #(.ADDR_W(16)) bus ();

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .MEM_LAT(1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  logic [15:0] mem [0:65535];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Synchronous-read memory; junk on MemData whenever no read was issued.
  always @(posedge Clk) begin
    if (bus.MemRdEn) bus.MemData <= mem[bus.MemAddr];
    else             bus.MemData <= 16'($urandom);
  end

  // Reference model: exp_addr is the address of the word owed to decode.
  logic [15:0] exp_addr = 16'h0000;
  bit          mon_en   = 1'b0;
  int          idle     = 0;

  always @(posedge Clk) begin
    if (Rst)                                  exp_addr = 16'h0000;
    else if (bus.Jump)                        exp_addr = bus.JumpAddr;
    else if (bus.InstrAck && bus.InstrValid)  exp_addr = exp_addr + 16'd1;
    else                                      exp_addr = exp_addr;
  end

  always @(negedge Clk) begin
    if (mon_en) begin
      if (bus.MemRdEn) chk("mon_memaddr", {16'h0, bus.MemAddr}, {16'h0, exp_addr});
      if (bus.InstrValid) begin
        chk("mon_instr", {16'h0, bus.Instr}, {16'h0, mem[exp_addr]});
        chk("mon_pc_hold", {16'h0, bus.PC}, {16'h0, exp_addr + 16'd1});
      end else begin
        chk("mon_pc", {16'h0, bus.PC}, {16'h0, exp_addr});
      end
`ifndef INSTR_FETCH_HALT_DETECT_EN
      chk("mon_halted", {31'h0, bus.Halted}, 32'h0);
`endif
      if (bus.InstrValid || bus.Halted || Rst || bus.Jump) idle = 0;
      else idle++;
      if (idle > 12) begin
        chk("mon_liveness", idle, 32'd0);
        idle = 0;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus.InstrValid && n < 20) begin tick(); n++; end
    if (!bus.InstrValid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rden(input string tag, output int n);
    n = 0;
    while (!bus.MemRdEn && n < 20) begin tick(); n++; end
    if (!bus.MemRdEn) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic ack_once();
    bus.InstrAck = 1'b1;
    tick();
    bus.InstrAck = 1'b0;
  endtask

  task automatic jump_to(input logic [15:0] a);
    bus.Jump     = 1'b1;
    bus.JumpAddr = a;
    tick();
    bus.Jump     = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    logic [15:0] w;
    for (int a = 0; a < 65536; a++) begin
      w = 16'($urandom);
      if (w == 16'h40F0) w = 16'h40F1;
      mem[a] = w;
    end
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    mem[5] = 16'h40F0;
    bus.InstrAck = 1'b0;
    bus.Jump     = 1'b0;
    bus.JumpAddr = 16'h0000;

    // Reset values
    do_reset();
    chk("rst_memaddr", {16'h0, bus.MemAddr}, 32'h0);
    chk("rst_valid", {31'h0, bus.InstrValid}, 32'h0);
    chk("rst_instr", {16'h0, bus.Instr}, 32'h0);
    chk("rst_rden", {31'h0, bus.MemRdEn}, 32'h0);
    chk("rst_pc", {16'h0, bus.PC}, 32'h0);
    chk("rst_halted", {31'h0, bus.Halted}, 32'h0);
    mon_en = 1'b1;

    // First fetch: single-cycle MemRdEn at address 0, valid two cycles later
    wait_rden("first_rden", n);
    chk("first_addr", {16'h0, bus.MemAddr}, 32'h0);
    tick();
    chk("rden_one_cycle", {31'h0, bus.MemRdEn}, 32'h0);
    chk("valid_n1", {31'h0, bus.InstrValid}, 32'h0);
    tick();
    chk("valid_n2", {31'h0, bus.InstrValid}, 32'h1);
    chk("seq_instr0", {16'h0, bus.Instr}, 32'h1234);

    // Sequential fetch: ack in cycle k -> valid in cycle k+3
    tick();
    ack_once();
    wait_valid("seq1", n);
    chk("seq1_latency", n, 32'd2);
    chk("seq_instr1", {16'h0, bus.Instr}, 32'h5678);
    tick();
    ack_once();
    wait_valid("seq2", n);
    chk("seq2_latency", n, 32'd2);
    chk("seq_instr2", {16'h0, bus.Instr}, 32'h9ABC);
    chk("seq_pc3", {16'h0, bus.PC}, 32'h3);
    ack_once();

    // Backpressure: no ack for 10 cycles
    do_reset();
    wait_valid("bp", n);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.MemRdEn) pulses++;
      chk("bp_instr", {16'h0, bus.Instr}, 32'h1234);
      chk("bp_valid", {31'h0, bus.InstrValid}, 32'h1);
    end
    chk("bp_no_rden", pulses, 32'd0);
    ack_once();
    wait_rden("bp_next", n);
    chk("bp_next_addr", {16'h0, bus.MemAddr}, 32'h1);

    // Jump in the capture cycle right after MemRdEn
    tick();
    jump_to(16'h0040);
    chk("jmp_valid_dropped", {31'h0, bus.InstrValid}, 32'h0);
    chk("jmp_pc", {16'h0, bus.PC}, 32'h0040);
    wait_rden("jmp_rden", n);
    chk("jmp_addr", {16'h0, bus.MemAddr}, 32'h0040);
    wait_valid("jmp_valid", n);
    chk("jmp_instr", {16'h0, bus.Instr}, {16'h0, mem[16'h0040]});

    // Jump together with ack: jump wins
    bus.InstrAck = 1'b1;
    jump_to(16'h0080);
    bus.InstrAck = 1'b0;
    chk("jmpack_valid", {31'h0, bus.InstrValid}, 32'h0);
    chk("jmpack_pc", {16'h0, bus.PC}, 32'h0080);
    wait_rden("jmpack_rden", n);
    chk("jmpack_addr", {16'h0, bus.MemAddr}, 32'h0080);
    wait_valid("jmpack_v", n);
    ack_once();

    // PC wrap
    jump_to(16'hFFFF);
    wait_valid("wrap", n);
    chk("wrap_instr", {16'h0, bus.Instr}, {16'h0, mem[16'hFFFF]});
    chk("wrap_pc", {16'h0, bus.PC}, 32'h0);
    ack_once();
    wait_rden("wrap_rden", n);
    chk("wrap_addr", {16'h0, bus.MemAddr}, 32'h0);
    wait_valid("wrap_v2", n);

    // Halt word at address 5
    jump_to(16'h0005);
    wait_valid("halt", n);
    chk("halt_instr", {16'h0, bus.Instr}, 32'h40F0);
    ack_once();
`ifdef INSTR_FETCH_HALT_DETECT_EN
    chk("halt_set", {31'h0, bus.Halted}, 32'h1);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.MemRdEn) pulses++;
    end
    chk("halt_no_rden", pulses, 32'd0);
    chk("halt_pc", {16'h0, bus.PC}, 32'h6);
    jump_to(16'h0010);
    chk("halt_clear", {31'h0, bus.Halted}, 32'h0);
    wait_rden("halt_resume", n);
    chk("halt_resume_addr", {16'h0, bus.MemAddr}, 32'h0010);
`else
    wait_rden("nohalt_rden", n);
    chk("nohalt_addr", {16'h0, bus.MemAddr}, 32'h6);
    chk("nohalt_halted", {31'h0, bus.Halted}, 32'h0);
`endif

    // Random phase: random acks (also while not valid) and random jumps
    for (int c = 0; c < 1500; c++) begin
      bus.Jump     = ($urandom_range(0, 39) == 0);
      bus.JumpAddr = 16'($urandom);
      bus.InstrAck = $urandom_range(0, 1) == 1;
      tick();
    end
    bus.Jump     = 1'b0;
    bus.InstrAck = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
